// File: rtl/uart_ring_buffer_param.sv
// Parametrised single-clock circular FIFO between a UART receiver and the bus side.
// Offers a selectable overflow policy, occupancy/threshold status, flush and a sticky overflow flag.
module uart_ring_buffer_param #(
  parameter int WIDTH             = 8,
  parameter int DEPTH             = 16,
  parameter int OVERWRITE         = 0,
  parameter int ALMOST_FULL_LEVEL = 12
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         writeEn,
  input  logic [WIDTH-1:0]             dataIn,
  input  logic                         readReq,
  input  logic                         flush,
  input  logic                         clearOverflow,
  output logic                         dataReadAck,
  output logic [WIDTH-1:0]             dataRead,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full,
  output logic                         almostFull,
  output logic                         overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] LP_AF    = CW'(ALMOST_FULL_LEVEL);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_ack;
  logic [WIDTH-1:0] r_data;
  logic             r_ovf;

  logic w_full;
  logic w_rd_ok;
  logic w_ovf_evt;
  logic w_ovw;
  logic w_wr_ok;

  // A full buffer with a same-cycle read is not an overflow: the read frees the slot.
  always_comb begin
    w_full    = (r_count == LP_DEPTH);
    w_rd_ok   = readReq && (r_count != '0);
    w_ovf_evt = writeEn && w_full && !w_rd_ok;
    w_ovw     = w_ovf_evt && (OVERWRITE != 0);
    w_wr_ok   = writeEn && (!w_ovf_evt || w_ovw);
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush && w_wr_ok) begin
      r_mem[r_wr_ptr] <= dataIn;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ack    <= 1'b0;
      r_data   <= '0;
      r_ovf    <= 1'b0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ack    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_ack <= w_rd_ok;
      if (w_rd_ok) begin
        r_data <= r_mem[r_rd_ptr];
      end
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      // Overwriting discards the oldest entry, so the read side moves with the write side.
      if (w_rd_ok || w_ovw) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_wr_ok && !w_rd_ok && !w_ovw) begin
        r_count <= r_count + CW'(1);
      end else if (w_rd_ok && !w_wr_ok) begin
        r_count <= r_count - CW'(1);
      end
      if (w_ovf_evt) begin
        r_ovf <= 1'b1;
      end else if (clearOverflow) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign dataReadAck = r_ack;
  assign dataRead    = r_data;
  assign count       = r_count;
  assign empty       = (r_count == '0);
  assign full        = (r_count == LP_DEPTH);
  assign almostFull  = (r_count >= LP_AF);
  assign overflow    = r_ovf;
endmodule

// File: tb/tb_uart_ring_buffer_param.sv
// Bench for uart_ring_buffer_param: drop-new and overwrite-oldest instances side by side,
// compared against queue-based models with a read-data scoreboard.
module tb_uart_ring_buffer_param;
  localparam int W   = 8;
  localparam int D   = 4;
  localparam int AFL = 3;
  localparam int CW  = $clog2(D + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic         writeEn = 1'b0;
  logic [W-1:0] dataIn = '0;
  logic         readReq = 1'b0;
  logic         flush = 1'b0;
  logic         clearOverflow = 1'b0;

  logic          ack [2];
  logic [W-1:0]  dr  [2];
  logic [CW-1:0] cnt [2];
  logic          emp [2];
  logic          ful [2];
  logic          af  [2];
  logic          ovf [2];

  uart_ring_buffer_param #(.WIDTH(W), .DEPTH(D), .OVERWRITE(0), .ALMOST_FULL_LEVEL(AFL)) u_drop (
    .clk(clk), .reset(reset), .writeEn(writeEn), .dataIn(dataIn), .readReq(readReq),
    .flush(flush), .clearOverflow(clearOverflow), .dataReadAck(ack[0]), .dataRead(dr[0]),
    .count(cnt[0]), .empty(emp[0]), .full(ful[0]), .almostFull(af[0]), .overflow(ovf[0]));

  uart_ring_buffer_param #(.WIDTH(W), .DEPTH(D), .OVERWRITE(1), .ALMOST_FULL_LEVEL(AFL)) u_ovw (
    .clk(clk), .reset(reset), .writeEn(writeEn), .dataIn(dataIn), .readReq(readReq),
    .flush(flush), .clearOverflow(clearOverflow), .dataReadAck(ack[1]), .dataRead(dr[1]),
    .count(cnt[1]), .empty(emp[1]), .full(ful[1]), .almostFull(af[1]), .overflow(ovf[1]));

  // Reference model: contents as a plain queue per policy, plus expected read words.
  logic [W-1:0] mq [2][$];
  logic [W-1:0] sb [2][$];
  bit           m_ovf  [2];
  bit           m_ack  [2];
  logic [W-1:0] m_last [2];
  bit           started = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (policy %0d) at %0t: got 0x%0h, expected 0x%0h", name, m, $time, act, exp);
    end
  endtask

  task automatic model_step(input int m, input bit rst, input bit we, input logic [W-1:0] d,
                            input bit rd, input bit fl, input bit clr);
    bit rd_ok;
    bit evt;
    rd_ok    = rd && (mq[m].size() > 0);
    evt      = 1'b0;
    m_ack[m] = 1'b0;
    if (rst) begin
      mq[m].delete();
      m_ovf[m]  = 1'b0;
      m_last[m] = '0;
    end else if (fl) begin
      mq[m].delete();
      m_ovf[m] = 1'b0;
    end else begin
      if (rd_ok) begin
        m_last[m] = mq[m].pop_front();
        m_ack[m]  = 1'b1;
        sb[m].push_back(m_last[m]);
      end
      if (we) begin
        if (mq[m].size() < D) begin
          mq[m].push_back(d);
        end else begin
          evt = 1'b1;
          if (m == 1) begin
            void'(mq[m].pop_front());
            mq[m].push_back(d);
          end
        end
      end
      if (clr) m_ovf[m] = 1'b0;
      if (evt) m_ovf[m] = 1'b1;
    end
  endtask

  task automatic cyc(input bit rst, input bit we, input logic [W-1:0] d,
                     input bit rd, input bit fl, input bit clr);
    @(negedge clk);
    reset = rst; writeEn = we; dataIn = d; readReq = rd; flush = fl; clearOverflow = clr;
    for (int m = 0; m < 2; m++) model_step(m, rst, we, d, rd, fl, clr);
    started = 1'b1;
  endtask

  task automatic wr(input logic [W-1:0] d); cyc(0, 1, d, 0, 0, 0); endtask
  task automatic rdc();                     cyc(0, 0, '0, 1, 0, 0); endtask
  task automatic idle();                    cyc(0, 0, '0, 0, 0, 0); endtask

  // Monitor: samples just after each active edge; read words are popped from the scoreboard.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (started) begin
        for (int m = 0; m < 2; m++) begin
          chk("dataReadAck", m, 32'(ack[m]), 32'(m_ack[m]));
          if (ack[m] === 1'b1) begin
            if (sb[m].size() == 0) begin
              chk("unexpected_ack", m, 32'(1), 32'(0));
            end else begin
              chk("read_data", m, 32'(dr[m]), 32'(sb[m].pop_front()));
            end
          end
          chk("dataRead_hold", m, 32'(dr[m]), 32'(m_last[m]));
          chk("count", m, 32'(cnt[m]), 32'(mq[m].size()));
          chk("empty", m, 32'(emp[m]), 32'(mq[m].size() == 0));
          chk("full", m, 32'(ful[m]), 32'(mq[m].size() == D));
          chk("almostFull", m, 32'(af[m]), 32'(mq[m].size() >= AFL));
          chk("overflow", m, 32'(ovf[m]), 32'(m_ovf[m]));
        end
      end
    end
  end

  initial begin
    // Ordered write/read with count 1,2,3,2,1,0.
    cyc(1, 0, '0, 0, 0, 0);
    wr(8'h12); wr(8'h23); wr(8'h34);
    rdc(); rdc(); rdc(); idle();
    // Five writes into four slots: drop-new versus overwrite-oldest, then drain and clear.
    wr(8'h12); wr(8'h23); wr(8'h34); wr(8'h45); wr(8'h56); idle();
    rdc(); rdc(); rdc(); rdc(); idle();
    cyc(0, 0, '0, 0, 0, 1); idle();
    // Simultaneous read and write on a full buffer.
    cyc(1, 0, '0, 0, 0, 0);
    wr(8'h01); wr(8'h02); wr(8'h03); wr(8'h04);
    cyc(0, 1, 8'h78, 1, 0, 0);
    rdc(); rdc(); rdc(); rdc(); idle();
    // Simultaneous read and write on an empty buffer, then read-while-empty hold.
    cyc(0, 1, 8'hAA, 1, 0, 0);
    rdc(); rdc(); idle();
    // Flush beats a same-cycle write; reset with readReq held clears dataRead.
    wr(8'h31); wr(8'h32); wr(8'h33); wr(8'h34); wr(8'h35); rdc();
    cyc(0, 1, 8'h99, 0, 1, 0);
    idle();
    wr(8'h41); wr(8'h42);
    cyc(1, 0, '0, 1, 0, 0);
    rdc(); idle();
    // Randomised traffic biased towards full/overflow conditions.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 55, W'($urandom),
          $urandom_range(0, 99) < 45, $urandom_range(0, 59) == 0, $urandom_range(0, 19) == 0);
    end
    idle(); idle();
    @(posedge clk); #2;
    for (int m = 0; m < 2; m++) chk("scoreboard_drained", m, 32'(sb[m].size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
